ldpc_enc: RTL and testbench
===========================

# ldpc_enc

Quasi-cyclic LDPC systematic encoder, the transmit-side counterpart of the decoder's syndrome check. It accepts R message blocks of D bits over a valid/ready stream and computes C parity blocks over GF(2). Each parity block is the XOR of circulant-rotated message blocks, using the same packed shift-value matrix format the checker consumes. It then streams the codeword out: R message blocks followed by C parity blocks.

## Interface
- `data_w`, 8: width of one shift value in `mtx`.
- `C`, 8: number of parity (check) blocks.
- `R`, 4: number of message blocks.
- `D`, 8: circulant size, i.e. bits per block.

Ports:
- `clk` input, 1: the single clock; all state updates on its rising edge.
- `rst` input, 1: reset, synchronous and active-high.
- `mtx` input, C*R*data_w: shift for check block i, message block j at `mtx[(i*R+j)*data_w +: data_w]`. Quasi-static: changes only while `busy`=0.
- `in_valid` input, 1: message block offered.
- `in_ready` output, 1: encoder accepts a message block.
- `in_data` input, D: message block.
- `out_valid` output, 1: codeword block valid.
- `out_ready` input, 1: downstream accepts the block.
- `out_data` output, D: codeword block.
- `out_parity` output, 1: current output block is parity.
- `out_last` output, 1: final block of the codeword.
- `busy` output, 1: a codeword is in progress, from the first accepted input through the last output handshake.

## Operation
- Circulant block for shift s:
  - s = all-ones → zero block.
  - s < D → rotate right by s: `(m >> s) | (m << (D-s))`, so s = 0 is identity.
  - D ≤ s < all-ones → zero block.
- States:
  - ACCEPT: `in_ready`=1, `out_valid`=0. Index j counts 0..R-1.
    - On each input handshake, store `in_data` into message buffer slot j.
    - For every i, parity[i] ^= circ(`in_data`, shift[i][j]).
    - Handshake with j = R-1 → EMIT, k = 0.
  - EMIT: `in_ready`=0, `out_valid`=1. Index k counts 0..R+C-1.
    - `out_data` = msg[k] for k < R, else parity[k-R].
    - `out_parity` = (k ≥ R); `out_last` = (k = R+C-1).
    - Output handshake advances k.
    - Handshake at k = R+C-1 → ACCEPT, with j=0 and all parity registers cleared.
- `in_data` is ignored when `in_ready`=0. There is no codeword overlap: the next message is not accepted until the current codeword has fully drained.
- Outputs are stable while `out_valid`=1 and `out_ready`=0.
- Reset (any state, including mid-codeword): state to ACCEPT, j=k=0, parity and message buffer cleared. The partial codeword is discarded with no `out_last`.

## Timing
- Reset values, in the cycle after `rst` is sampled high:
  - `out_valid`, `out_parity`, `out_last`, `busy` = 0; `out_data` = 0.
  - `in_ready` = 0 while `rst` is high, and 1 in the first cycle after deassertion.
- Input accepts: one per cycle at full rate; gaps in `in_valid` only stall j.
- Latency: `out_valid` rises the cycle after the R-th input handshake, with k=0.
- Output: one block per cycle while `out_ready`=1.
- Turnaround: `in_ready` rises the cycle after the `out_last` handshake.
- Minimum period: 2R+C cycles per codeword.
- All outputs are registered or decoded from registered state; there are no combinational paths from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `ldpc_pkg` holds:
  - default parameter constants;
  - the state enum {ACCEPT, EMIT};
  - the shift-decode constant SHIFT_ZERO = all-ones.
- The checker should import the same package.
- One sub-module, `ldpc_circ_shift`: combinational (block, shift) → rotated block or zero. It is instantiated C times in the accumulate path and is reusable by the checker.
- Expected size: roughly 200 lines.

## Test plan
Defaults are D=8, R=4, C=8.
1. Identity: shift[i][i]=0 for i<4, all others 0xFF; input 01,02,04,08 → output 01,02,04,08,01,02,04,08,00,00,00,00. `out_parity` is set on beats 5-12 and `out_last` on beat 12.
2. All shifts 1; input 01,02,04,08 → message echoed, then all 8 parity blocks = 0x87 (80^01^02^04).
3. Out-of-range shifts: all shifts 8 (and separately 0xFF) → all parity 00. Shift 7 on block 0 only with input 01 → that parity 0x02.
4. Backpressure: toggle `out_ready` 1,0,0,1,… during EMIT → `out_data`, `out_parity`, `out_last` held while stalled. The order is unchanged and there are exactly 12 handshakes.
5. Input gaps and back-to-back codewords: `in_valid` with bubbles, second codeword offered during EMIT → `in_ready`=0 until the cycle after `out_last`. The second parity is independent of the first, i.e. parity is cleared between codewords.
6. Reset mid-EMIT at k=6 → next cycle `out_valid`=0, `busy`=0. The following codeword is correct.

Source files
------------

// File: rtl/ldpc_pkg.sv
// ldpc_pkg: constants and types shared by the QC-LDPC encoder and syndrome checker.
//   DATA_W_DEF / C_DEF / R_DEF / D_DEF : default shift width, parity blocks,
//                                        message blocks and circulant size
//   state_t                            : encoder phase {ACCEPT, EMIT}
//   SHIFT_ZERO                         : shift code that selects an all-zero circulant
package ldpc_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int C_DEF      = 8;
    localparam int R_DEF      = 4;
    localparam int D_DEF      = 8;

    typedef enum logic {
        ACCEPT = 1'b0,
        EMIT   = 1'b1
    } state_t;

    // All-ones shift code means "no connection" between a check and message block.
    localparam logic [DATA_W_DEF-1:0] SHIFT_ZERO = '1;

endpackage

// File: rtl/ldpc_circ_shift.sv
// ldpc_circ_shift: one circulant of the parity-check matrix applied to one block.
//   blk   : input block, D bits
//   shift : packed shift code, data_w bits
//   rot   : blk rotated right by shift when shift < D, otherwise all zeros
//           (both the all-ones code and unused codes D..all-ones-1 give zero)
// Purely combinational; shared between the encoder and the checker.
module ldpc_circ_shift
    import ldpc_pkg::*;
#(
    parameter int data_w = DATA_W_DEF,
    parameter int D      = D_DEF
) (
    input  logic [D-1:0]      blk,
    input  logic [data_w-1:0] shift,
    output logic [D-1:0]      rot
);

    // Same meaning as SHIFT_ZERO, sized to this instance's shift width.
    localparam logic [data_w-1:0] ZERO_CODE = '1;

    // Enumerating the legal shifts keeps every rotation a constant one and
    // leaves the result at zero for any code that matches none of them.
    always_comb begin
        rot = '0;
        for (int s = 0; s < D; s++) begin
            if (shift == data_w'(s) && shift != ZERO_CODE) begin
                rot = (blk >> s) | (blk << (D - s));
            end
        end
    end

endmodule

// File: rtl/ldpc_enc.sv
// ldpc_enc: quasi-cyclic LDPC systematic encoder.
//   clk, rst   : clock, synchronous active-high reset
//   mtx        : shift codes, check block i / message block j at
//                mtx[(i*R+j)*data_w +: data_w]; only changes while busy=0
//   in_*       : message block stream (valid/ready)
//   out_*      : codeword stream (valid/ready); out_parity marks parity blocks,
//                out_last marks the final block of the codeword
//   busy       : from the first accepted input block until the last output handshake
// Accepts R message blocks, accumulating C parity blocks on the fly, then emits
// the R message blocks followed by the C parity blocks.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; a source holds data and valid until that edge, and neither ready nor any
// output depends combinationally on the partner's valid/ready.
module ldpc_enc
    import ldpc_pkg::*;
#(
    parameter int data_w = DATA_W_DEF,
    parameter int C      = C_DEF,
    parameter int R      = R_DEF,
    parameter int D      = D_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [C*R*data_w-1:0]   mtx,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [D-1:0]            in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [D-1:0]            out_data,
    output logic                    out_parity,
    output logic                    out_last,
    output logic                    busy
);

    localparam int JW = (R > 1) ? $clog2(R) : 1;
    localparam int KW = $clog2(R + C);
    localparam logic [JW-1:0] J_LAST = JW'(R - 1);
    localparam logic [KW-1:0] K_LAST = KW'(R + C - 1);
    localparam logic [KW-1:0] K_PAR  = KW'(R);

    state_t            state;
    state_t            state_nx;
    logic [JW-1:0]     j;
    logic [KW-1:0]     k;
    logic [D-1:0]      msg    [R];
    logic [D-1:0]      parity [C];
    logic [data_w-1:0] shift_sel [C];
    logic [D-1:0]      circ      [C];
    logic              in_hs;
    logic              out_hs;

    assign in_hs  = in_ready & in_valid;
    assign out_hs = out_valid & out_ready;

    // Pick column j of the shift matrix for every check row.
    always_comb begin
        for (int i = 0; i < C; i++) begin
            shift_sel[i] = '0;
            for (int jj = 0; jj < R; jj++) begin
                if (j == JW'(jj)) begin
                    shift_sel[i] = mtx[(i * R + jj) * data_w +: data_w];
                end
            end
        end
    end

    for (genvar gi = 0; gi < C; gi++) begin : g_circ
        ldpc_circ_shift #(
            .data_w (data_w),
            .D      (D)
        ) u_circ (
            .blk   (in_data),
            .shift (shift_sel[gi]),
            .rot   (circ[gi])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCEPT;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ACCEPT: if (in_hs && j == J_LAST) state_nx = EMIT;
            EMIT:   if (out_hs && k == K_LAST) state_nx = ACCEPT;
            default: state_nx = ACCEPT;
        endcase
    end

    // Outputs decoded from registered state. in_ready is also held low while
    // rst is asserted so nothing is offered a handshake during reset.
    always_comb begin
        in_ready   = (state == ACCEPT) && !rst;
        out_valid  = (state == EMIT);
        out_parity = (state == EMIT) && (k >= K_PAR);
        out_last   = (state == EMIT) && (k == K_LAST);
        busy       = (state == EMIT) || (j != '0);
        out_data   = '0;
        if (state == EMIT) begin
            for (int b = 0; b < R; b++) begin
                if (k == KW'(b)) out_data = msg[b];
            end
            for (int b = 0; b < C; b++) begin
                if (k == KW'(R + b)) out_data = parity[b];
            end
        end
    end

    // Message buffer, parity accumulators and block indices.
    always_ff @(posedge clk) begin
        if (rst) begin
            j <= '0;
            k <= '0;
            for (int b = 0; b < R; b++) msg[b] <= '0;
            for (int i = 0; i < C; i++) parity[i] <= '0;
        end else begin
            if (in_hs) begin
                for (int b = 0; b < R; b++) begin
                    if (j == JW'(b)) msg[b] <= in_data;
                end
                for (int i = 0; i < C; i++) begin
                    parity[i] <= parity[i] ^ circ[i];
                end
                j <= (j == J_LAST) ? '0 : j + JW'(1);
            end
            if (out_hs) begin
                if (k == K_LAST) begin
                    // Codeword done: start the next one from a clean accumulator.
                    k <= '0;
                    for (int i = 0; i < C; i++) parity[i] <= '0;
                end else begin
                    k <= k + KW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ldpc_enc.sv
// tb_ldpc_enc: directed table-driven bench for ldpc_enc at D=8, R=4, C=8.
// Each table entry holds a shift matrix, a message and hand-computed parity;
// hand-written sequences cover backpressure, input gaps with back-to-back
// codewords, and reset in the middle of a codeword.
module tb_ldpc_enc;

    localparam int D  = 8;
    localparam int R  = 4;
    localparam int C  = 8;
    localparam int DW = 8;
    localparam int MW = C * R * DW;
    localparam int BW = D + 2;   // {parity, last, data}
    localparam int NV = 6;

    typedef struct packed {
        logic [MW-1:0]         mtx;
        logic [R-1:0][D-1:0]   msg;
        logic [C-1:0][D-1:0]   par;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [MW-1:0] mtx;
    logic          in_valid;
    logic          in_ready;
    logic [D-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [D-1:0]  out_data;
    logic          out_parity;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    ldpc_enc #(
        .data_w (DW),
        .C      (C),
        .R      (R),
        .D      (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mtx        (mtx),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_parity (out_parity),
        .out_last   (out_last),
        .busy       (busy)
    );

    // ---------------- scoreboard ----------------
    int             total = 0;
    int             bad   = 0;
    logic [BW-1:0]  exp_q[$];
    logic [D-1:0]   send_q[$];
    vec_t           vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [MW-1:0] put(input logic [MW-1:0] m, input int i, input int jj,
                                          input logic [DW-1:0] s);
        logic [MW-1:0] r;
        r = m;
        r[(i * R + jj) * DW +: DW] = s;
        return r;
    endfunction

    function automatic logic [MW-1:0] fill(input logic [DW-1:0] s);
        logic [MW-1:0] r;
        r = '0;
        for (int i = 0; i < C; i++)
            for (int jj = 0; jj < R; jj++)
                r = put(r, i, jj, s);
        return r;
    endfunction

    // Queue the message for sending and the full expected codeword.
    task automatic load(input int v);
        for (int b = 0; b < R; b++) begin
            send_q.push_back(vecs[v].msg[b]);
            exp_q.push_back({1'b0, 1'b0, vecs[v].msg[b]});
        end
        for (int i = 0; i < C; i++) begin
            exp_q.push_back({1'b1, (i == C - 1) ? 1'b1 : 1'b0, vecs[v].par[i]});
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; a block offered while in_ready is high
    // is taken on the following rising edge.
    task automatic drive_in(input bit gaps);
        int budget;
        budget = 400;
        while (send_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = D'($urandom_range(0, 255));
            end else begin
                in_valid = 1'b1;
                in_data  = send_q[0];
                if (in_ready) void'(send_q.pop_front());
            end
        end
        check("send_all_blocks", send_q.size(), 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        check("latency_out_valid", out_valid, 1);
    endtask

    // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0 repeating.
    task automatic collect(input int n, input int mode, output int got);
        int            budget;
        int            cnt;
        bit            stall;
        logic [BW-1:0] held;
        logic [BW-1:0] beat;
        budget = 400;
        cnt    = 0;
        stall  = 1'b0;
        held   = '0;
        got    = 0;
        while (got < n && budget > 0) begin
            @(negedge clk);
            budget--;
            beat = {out_parity, out_last, out_data};
            if (stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_beat", beat, held);
            end
            out_ready = (mode == 1) ? ((cnt % 3) == 0) : 1'b1;
            cnt++;
            if (out_valid) begin
                check("in_ready_low_in_emit", in_ready, 0);
                check("busy_in_emit", busy, 1);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", beat, '0);
                    end else begin
                        check("beat", beat, exp_q.pop_front());
                    end
                    got++;
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    held  = beat;
                end
            end else begin
                stall = 1'b0;
            end
        end
        check("handshake_count", got, n);
    endtask

    task automatic turnaround();
        @(negedge clk);
        check("turnaround_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic run(input int v, input bit gaps, input int mode);
        int got;
        mtx = vecs[v].mtx;
        load(v);
        fork
            drive_in(gaps);
            collect(R + C, mode, got);
        join
        turnaround();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- test ----------------
    initial begin
        int got;

        // Vector table: shift matrices, messages and hand-computed parity.
        // 0: identity on the first four rows, others disconnected.
        vecs[0].mtx = fill(8'hFF);
        for (int i = 0; i < R; i++) vecs[0].mtx = put(vecs[0].mtx, i, i, 8'h00);
        vecs[0].msg = {8'h08, 8'h04, 8'h02, 8'h01};
        vecs[0].par = {8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h04, 8'h02, 8'h01};
        // 1: every shift 1 -> 80^01^02^04 = 87 in every row.
        vecs[1].mtx = fill(8'h01);
        vecs[1].msg = {8'h08, 8'h04, 8'h02, 8'h01};
        vecs[1].par = {C{8'h87}};
        // 2: shift 8 is out of range -> zero blocks.
        vecs[2].mtx = fill(8'h08);
        vecs[2].msg = {8'h08, 8'h04, 8'h02, 8'h01};
        vecs[2].par = '0;
        // 3: all-ones code -> zero blocks.
        vecs[3].mtx = fill(8'hFF);
        vecs[3].msg = {8'h08, 8'h04, 8'h02, 8'h01};
        vecs[3].par = '0;
        // 4: shift 7 on row 0 / block 0 only, message 01 -> parity 0 = 02.
        vecs[4].mtx = put(fill(8'hFF), 0, 0, 8'h07);
        vecs[4].msg = {8'h00, 8'h00, 8'h00, 8'h01};
        vecs[4].par = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
        // 5: row i: block0 shift i, block1 off, block2 shift 8, block3 shift 0.
        //    parity[i] = rotr(A5, i) ^ 81.
        vecs[5].mtx = fill(8'hFF);
        for (int i = 0; i < C; i++) begin
            vecs[5].mtx = put(vecs[5].mtx, i, 0, DW'(i));
            vecs[5].mtx = put(vecs[5].mtx, i, 2, 8'h08);
            vecs[5].mtx = put(vecs[5].mtx, i, 3, 8'h00);
        end
        vecs[5].msg = {8'h81, 8'h0F, 8'h3C, 8'hA5};
        vecs[5].par = {8'hCA, 8'h17, 8'hAC, 8'hDB, 8'h35, 8'hE8, 8'h53, 8'h24};

        // Reset state.
        rst       = 1'b1;
        mtx       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_parity", out_parity, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Table-driven codewords at full rate.
        for (int v = 0; v < NV; v++) begin
            run(v, 1'b0, 0);
        end

        // Backpressure on the output stream.
        run(0, 1'b0, 1);
        run(5, 1'b0, 1);

        // Input bubbles and a second codeword offered while the first drains;
        // the identical message must give identical parity both times.
        mtx = vecs[5].mtx;
        load(5);
        load(5);
        fork
            drive_in(1'b1);
            begin
                collect(R + C, 0, got);
                @(negedge clk);
                check("b2b_turnaround_in_ready", in_ready, 1);
                check("b2b_idle_out_valid", out_valid, 0);
                collect(R + C, 0, got);
            end
        join
        turnaround();

        // Reset after six output handshakes (k = 6).
        mtx = vecs[1].mtx;
        load(1);
        fork
            drive_in(1'b0);
            collect(6, 0, got);
        join
        exp_q.delete();
        @(negedge clk);
        check("pre_rst_out_valid", out_valid, 1);
        rst       = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_release_in_ready", in_ready, 1);
        run(1, 1'b0, 0);
        run(4, 1'b0, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
